// File: rtl/axi_pkg.sv
// Shared encodings for the AXI read-channel slave: burst types, response codes,
// response FIFO depth and the responder state enum.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  localparam logic [2:0] SIZE_4B = 3'b010;

  localparam int unsigned RESP_FIFO_DEPTH = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/axi_rd_resp_fifo.sv
// Three-entry synchronous FIFO holding {RDATA, RRESP, RLAST} beats awaiting the
// R handshake. Head is the oldest entry; count/empty drive issue credit.
module axi_rd_resp_fifo
  import axi_pkg::*;
#(
  parameter int unsigned WIDTH = 35
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [1:0]       count,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam logic [1:0] LastIdx = 2'(RESP_FIFO_DEPTH - 1);
  localparam logic [1:0] Full    = 2'(RESP_FIFO_DEPTH);

  logic [WIDTH-1:0] mem_q [RESP_FIFO_DEPTH];
  logic [1:0]       wr_ptr_q, rd_ptr_q, count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == 2'd0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // Push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push && ((count_q != Full) || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 2'd0;
      for (int i = 0; i < int'(RESP_FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= (wr_ptr_q == LastIdx) ? 2'd0 : wr_ptr_q + 2'd1;
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == LastIdx) ? 2'd0 : rd_ptr_q + 2'd1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/axi_slave_read_channel.sv
// AXI4 read-channel slave: one AR burst at a time, 1-cycle-latency local memory reads,
// R beats via a 3-entry FIFO. Define AXI_SLV_RD_RANGE_CHK_EN for SLVERR on out-of-range beats.
module axi_slave_read_channel
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH         = 32,
  parameter int unsigned READ_CHANNEL_WIDTH = 32,
  parameter int unsigned READ_BURST_LEN     = 8,
  parameter int unsigned MEM_ADDR_WIDTH     = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ARVALID,
  output logic                          ARREADY,
  input  logic [ADDR_WIDTH-1:0]         ARADDR,
  input  logic [READ_BURST_LEN-1:0]     ARLEN,
  input  logic [2:0]                    ARSIZE,
  input  logic [1:0]                    ARBURST,
  output logic                          RVALID,
  input  logic                          RREADY,
  output logic [READ_CHANNEL_WIDTH-1:0] RDATA,
  output logic                          RLAST,
  output logic [1:0]                    RRESP,
  output logic                          mem_ren,
  output logic [MEM_ADDR_WIDTH-1:0]     mem_raddr,
  input  logic [READ_CHANNEL_WIDTH-1:0] mem_rdata
);

  localparam int unsigned EntryW = READ_CHANNEL_WIDTH + 3;

  state_e                        state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0]     base_q;
  logic [READ_BURST_LEN-1:0]     len_q;
  logic [1:0]                    burst_q;
  logic [READ_BURST_LEN:0]       issued_q;
  logic                          inflight_q, inflight_last_q, inflight_err_q;

  logic                          ar_hs, issue, beat_err, beat_last, r_hs, last_hs;
  logic [READ_BURST_LEN:0]       beat_off;
  logic [1:0]                    fifo_count;
  logic                          fifo_empty;
  logic [EntryW-1:0]             fifo_wdata, fifo_head;
  logic [READ_CHANNEL_WIDTH-1:0] head_data;
  logic [1:0]                    head_resp;
  logic                          head_last;
  logic                          unused_bits;

  assign unused_bits = ^{ARSIZE ^ SIZE_4B, ARADDR};

  assign ARREADY   = rst_n && (state_q == IDLE);
  assign ar_hs     = ARVALID && ARREADY;
  assign beat_last = (issued_q == {1'b0, len_q});
  // Credit counts both queued beats and the read whose data lands next cycle.
  assign issue     = (state_q == ACTIVE) && (issued_q <= {1'b0, len_q}) &&
                     ((3'(fifo_count) + 3'(inflight_q)) < 3'(RESP_FIFO_DEPTH));

  always_comb begin
    beat_off = '0;
    case (burst_q)
      BURST_INCR, BURST_WRAP: beat_off = issued_q;
      default:                beat_off = '0;
    endcase
  end

  assign mem_raddr = base_q + MEM_ADDR_WIDTH'(beat_off);
  assign mem_ren   = issue && !beat_err;

`ifdef AXI_SLV_RD_RANGE_CHK_EN
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] beat_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else if (ar_hs) begin
      addr_q <= ARADDR;
    end
  end

  assign beat_addr = addr_q + (ADDR_WIDTH'(beat_off) << 2);
  assign beat_err  = issue && ((beat_addr >> (MEM_ADDR_WIDTH + 2)) != '0);
`else
  assign beat_err = 1'b0;
`endif

  assign fifo_wdata = {inflight_err_q ? '0 : mem_rdata,
                       inflight_err_q ? SLVERR : OKAY,
                       inflight_last_q};

  axi_rd_resp_fifo #(
    .WIDTH (EntryW)
  ) u_resp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight_q),
    .wdata (fifo_wdata),
    .pop   (r_hs),
    .count (fifo_count),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign {head_data, head_resp, head_last} = fifo_head;

  assign RVALID  = !fifo_empty;
  assign RDATA   = fifo_empty ? '0 : head_data;
  assign RRESP   = fifo_empty ? OKAY : head_resp;
  assign RLAST   = !fifo_empty && head_last;
  assign r_hs    = RVALID && RREADY;
  assign last_hs = r_hs && head_last;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ar_hs) state_d = ACTIVE;
      ACTIVE:  if (last_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      base_q          <= '0;
      len_q           <= '0;
      burst_q         <= BURST_FIXED;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      inflight_err_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && beat_last;
      inflight_err_q  <= beat_err;
      if (ar_hs) begin
        base_q   <= ARADDR[MEM_ADDR_WIDTH+1:2];
        len_q    <= ARLEN;
        burst_q  <= ARBURST;
        issued_q <= '0;
      end else if (last_hs) begin
        issued_q <= '0;
      end else if (issue) begin
        issued_q <= issued_q + (READ_BURST_LEN + 1)'(1);
      end
    end
  end

endmodule

// File: doc/axi_slave_read_channel.md
Name: axi_slave_read_channel

Overview:
AXI4 read-channel responder, the slave end of the master read channel. Accepts one AR request at a time and turns it into 1-cycle-latency reads on a local synchronous memory port. Returns the resulting R beats with correct RLAST under arbitrary RREADY backpressure. Sits in front of the data/instruction memory model on the AXI interconnect.

Parameters:
ADDR_WIDTH, 32, AR byte-address width
READ_CHANNEL_WIDTH, 32, RDATA / memory word width; beat size fixed at 4 bytes
READ_BURST_LEN, 8, ARLEN width; beats per burst = ARLEN+1 (1..256)
MEM_ADDR_WIDTH, 10, local memory word-address width

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
ARVALID  in  1  address valid
ARREADY  out  1  address ready
ARADDR  in  ADDR_WIDTH  start byte address
ARLEN  in  READ_BURST_LEN  beats-1
ARSIZE  in  3  ignored; 3'b010 assumed by protocol contract
ARBURST  in  2  00 FIXED, 01 INCR, 10 WRAP (handled as INCR)
RVALID  out  1  read data valid
RREADY  in  1  master ready
RDATA  out  READ_CHANNEL_WIDTH  beat data
RLAST  out  1  final beat
RRESP  out  2  response code
mem_ren  out  1  memory read strobe
mem_raddr  out  MEM_ADDR_WIDTH  memory word address
mem_rdata  in  READ_CHANNEL_WIDTH  valid the cycle after mem_ren

Behaviour:
- Reset: state IDLE, beat/issue counters 0, response FIFO empty, inflight 0. Outputs RVALID=0, RLAST=0, RRESP=0, RDATA=0, mem_ren=0, mem_raddr=0. ARREADY=0 while rst_n=0.
- States: IDLE, ACTIVE.
- IDLE: ARREADY=1. On ARVALID&&ARREADY, latch word address ARADDR[MEM_ADDR_WIDTH+1:2], ARLEN, ARBURST, clear counters, go ACTIVE.
- ACTIVE: ARREADY=0. Any ARVALID arriving here, including in the same cycle as the last R handshake, waits and is accepted on the first IDLE cycle.
- Issue rule: mem_ren=1 when issued_cnt<=ARLEN and fifo_count+inflight<3. No combinational path from RREADY to mem_ren.
- mem_raddr = base + issued_cnt for INCR/WRAP; base for FIXED. Wraps modulo 2^MEM_ADDR_WIDTH.
- inflight register = mem_ren of the previous cycle. The cycle after an issue, {mem_rdata, RRESP=2'b00, last=(beat index==ARLEN)} is pushed into a 3-entry FIFO.
- R outputs come from the FIFO head: RVALID=!empty. Pop on RVALID&&RREADY. RDATA, RLAST and RRESP stay stable while RVALID&&!RREADY.
- Latency: AR handshake at cycle 0, mem_ren at cycle 1, FIFO write at end of cycle 2, RVALID at cycle 3. With RREADY held high: one beat per cycle, no bubbles.
- Return to IDLE on the handshake of the beat with RLAST=1. Counters clear; FIFO is empty at that point.
- Simultaneous push and pop at full count is legal, and count is unchanged. The issue rule guarantees the FIFO never overflows.
- rst_n low mid-burst: burst abandoned, FIFO flushed, RVALID drops the next cycle. No further beats of that burst are sent.

Optional Feature:
AXI_SLV_RD_RANGE_CHK_EN
- Defined: a beat whose byte address is >= 4*2^MEM_ADDR_WIDTH (full ADDR_WIDTH compare, before truncation) is not issued to memory (mem_ren=0 for that slot). A FIFO entry with RDATA=0 and RRESP=2'b10 (SLVERR) is pushed instead, using the same latency and credit accounting. The burst still completes with correct RLAST.
- Undefined: upper address bits are ignored and the address aliases. RRESP is always 2'b00.

Decomposition:
- Package axi_pkg: burst encodings (BURST_FIXED/INCR/WRAP), RRESP codes (OKAY=2'b00, SLVERR=2'b10), SIZE_4B=3'b010, state encoding IDLE/ACTIVE.
- One sub-module: axi_rd_resp_fifo. A 3-entry synchronous FIFO of {RDATA, RRESP, RLAST} with push, pop, count, empty and head outputs, sharing clk/rst_n.

Test Plan:
- ARADDR=0x40, ARLEN=0, INCR, mem[0x10]=0xDEAD → mem_raddr=0x10 at cycle 1; RVALID at cycle 3 with RDATA=0xDEAD, RLAST=1, RRESP=0; ARREADY=1 the cycle after the handshake.
- ARADDR=0x100, ARLEN=7, mem[0x40+i]=3*i, RREADY=1 → beats 0,3,...,21 on 8 consecutive cycles; RLAST only on the 8th.
- Same burst with RREADY random at 30% duty → identical data sequence with no loss or duplication; fifo_count+inflight never exceeds 3; RDATA stable while stalled.
- ARBURST=FIXED, ARADDR=0x20, ARLEN=3 → mem_raddr=0x8 on all 4 issues; 4 beats, RLAST on the 4th.
- Reset asserted after 2 of 8 beats, then ARLEN=1 issued → RVALID=0 the cycle after reset; only 2 new beats are returned with correct RLAST.
- (With AXI_SLV_RD_RANGE_CHK_EN) ARADDR=0xFFC, ARLEN=1 → beat 0 OKAY from mem[0x3FF]; beat 1 RRESP=2'b10, RDATA=0, RLAST=1, no mem_ren for it.
